// File: rtl/sprite_overlay.sv
// Single-sprite compositor: places a ROM-backed sprite with integer upscaling over the background pixel.
// Define SPRITE_TRANSPARENCY_EN to make texels equal to TRANSP_IDX show the background.
module sprite_overlay #(
   parameter int SPR_W      = 55,
   parameter int SPR_H      = 247,
   parameter int SCALE      = 1,
   parameter int ADDR_W     = 14,
   parameter int IDX_W      = 4,
   parameter int TRANSP_IDX = 0
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              enable,
   input  logic [3:0]        bg_red,
   input  logic [3:0]        bg_green,
   input  logic [3:0]        bg_blue,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              sprite_hit
);

   localparam int CIW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RIW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   localparam int SW  = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [CIW-1:0]    COL_LAST = CIW'(SPR_W - 1);
   localparam logic [RIW-1:0]    ROW_LAST = RIW'(SPR_H - 1);
   localparam logic [SW-1:0]     SUB_LAST = SW'(SCALE - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SPR_W);

   // frame-latched placement
   logic [9:0]        px_q, px_d;
   logic [9:0]        py_q, py_d;
   logic              en_q, en_d;

   // row tracking
   logic [RIW-1:0]    row_idx_q, row_idx_d;
   logic [SW-1:0]     row_sub_q, row_sub_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic              row_act_q, row_act_d;

   // column tracking: _c is the value used by the current pixel, _d what the next pixel inherits
   logic [CIW-1:0]    col_idx_q, col_idx_c, col_idx_d;
   logic [SW-1:0]     col_sub_q, col_sub_c, col_sub_d;
   logic              col_act_q, col_act_c, col_act_d;

   // stage 1
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              in_win_q, in_win_d;
   logic              blank_d1_q;
   logic [11:0]       bg_d1_q;

   // stage 2
   logic [11:0]       rgb_q, rgb_d;
   logic              hit_q, hit_d;
   logic              opaque;

   always_comb begin
      px_d = px_q;
      py_d = py_q;
      en_d = en_q;
      if (DrawX == '0 && DrawY == '0) begin
         px_d = pos_x;
         py_d = pos_y;
         en_d = enable;
      end
   end

   // the freshly latched py is used so a sprite at y=0 starts on the latch pixel
   always_comb begin
      row_idx_d  = row_idx_q;
      row_sub_d  = row_sub_q;
      row_base_d = row_base_q;
      row_act_d  = row_act_q;
      if (DrawX == '0) begin
         if (DrawY == py_d) begin
            row_idx_d  = '0;
            row_sub_d  = '0;
            row_base_d = '0;
            row_act_d  = 1'b1;
         end else if (row_act_q) begin
            if (row_sub_q == SUB_LAST) begin
               row_sub_d = '0;
               if (row_idx_q == ROW_LAST) begin
                  row_act_d = 1'b0;
               end else begin
                  row_idx_d  = row_idx_q + RIW'(1);
                  row_base_d = row_base_q + ROW_STEP;
               end
            end else begin
               row_sub_d = row_sub_q + SW'(1);
            end
         end
      end
   end

   always_comb begin
      col_idx_c = col_idx_q;
      col_sub_c = col_sub_q;
      col_act_c = col_act_q;
      if (row_act_d && DrawX == px_d) begin
         col_idx_c = '0;
         col_sub_c = '0;
         col_act_c = 1'b1;
      end

      col_idx_d = col_idx_c;
      col_sub_d = col_sub_c;
      col_act_d = col_act_c;
      if (col_act_c) begin
         if (col_sub_c == SUB_LAST) begin
            col_sub_d = '0;
            if (col_idx_c == COL_LAST) begin
               col_act_d = 1'b0;
            end else begin
               col_idx_d = col_idx_c + CIW'(1);
            end
         end else begin
            col_sub_d = col_sub_c + SW'(1);
         end
      end
   end

   always_comb begin
      addr_d   = row_base_d + ADDR_W'(col_idx_c);
      in_win_d = en_d & row_act_d & col_act_c;
   end

`ifdef SPRITE_TRANSPARENCY_EN
   assign opaque = (rom_q != IDX_W'(TRANSP_IDX));
`else
   logic unused_idx;
   assign unused_idx = ^{rom_q, IDX_W'(TRANSP_IDX)};
   assign opaque     = 1'b1;
`endif

   always_comb begin
      rgb_d = '0;
      hit_d = 1'b0;
      if (blank_d1_q) begin
         if (in_win_q && opaque) begin
            rgb_d = {pal_red, pal_green, pal_blue};
            hit_d = 1'b1;
         end else begin
            rgb_d = bg_d1_q;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         px_q       <= '0;
         py_q       <= '0;
         en_q       <= 1'b0;
         row_idx_q  <= '0;
         row_sub_q  <= '0;
         row_base_q <= '0;
         row_act_q  <= 1'b0;
         col_idx_q  <= '0;
         col_sub_q  <= '0;
         col_act_q  <= 1'b0;
         addr_q     <= '0;
         in_win_q   <= 1'b0;
         blank_d1_q <= 1'b0;
         bg_d1_q    <= '0;
         rgb_q      <= '0;
         hit_q      <= 1'b0;
      end else begin
         px_q       <= px_d;
         py_q       <= py_d;
         en_q       <= en_d;
         row_idx_q  <= row_idx_d;
         row_sub_q  <= row_sub_d;
         row_base_q <= row_base_d;
         row_act_q  <= row_act_d;
         col_idx_q  <= col_idx_d;
         col_sub_q  <= col_sub_d;
         col_act_q  <= col_act_d;
         addr_q     <= addr_d;
         in_win_q   <= in_win_d;
         blank_d1_q <= blank;
         bg_d1_q    <= {bg_red, bg_green, bg_blue};
         rgb_q      <= rgb_d;
         hit_q      <= hit_d;
      end
   end

   assign rom_address = addr_q;
   assign red         = rgb_q[11:8];
   assign green       = rgb_q[7:4];
   assign blue        = rgb_q[3:0];
   assign sprite_hit  = hit_q;

endmodule

// File: tb/tb_sprite_overlay.sv
// Randomized bench for sprite_overlay on a reduced 64x24 raster, two instances (SCALE 1 and 3)
// checked against a geometric reference model (window test plus texel = (dy/S)*W + dx/S).
module tb_sprite_overlay;

   localparam int SPR_W = 4;
   localparam int SPR_H = 2;
   localparam int H_TOT = 64;
   localparam int V_TOT = 24;
   localparam int VIS_W = 48;
   localparam int VIS_H = 20;
   localparam int NF    = 12;

   typedef struct packed {
      logic        v;
      logic        inwin;
      logic [3:0]  addr;
      logic        blank;
      logic [11:0] bg;
   } px_t;

   logic       vga_clk = 1'b0;
   logic       reset;
   logic [9:0] DrawX, DrawY, pos_x, pos_y;
   logic       blank, enable;
   logic [3:0] bg_red, bg_green, bg_blue;

   logic [3:0] addr1, q1, pr1, pg1, pb1, r1, g1, b1;
   logic [3:0] addr3, q3, pr3, pg3, pb3, r3, g3, b3;
   logic       hit1, hit3;

   logic [3:0] rom_mem [16];

   int  n_checks = 0;
   int  n_fail   = 0;
   int  mpx, mpy;
   bit  men;
   bit  bg_fixed_red;
   px_t prev1, prev3;

   always #5 vga_clk = ~vga_clk;

   // sync ROM whose data settles within the cycle after the address changes
   always @(negedge vga_clk) begin
      q1 <= rom_mem[addr1];
      q3 <= rom_mem[addr3];
   end

   assign pr1 = q1;
   assign pg1 = q1 ^ 4'hA;
   assign pb1 = ~q1;
   assign pr3 = q3;
   assign pg3 = q3 ^ 4'hA;
   assign pb3 = ~q3;

   sprite_overlay #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(1), .ADDR_W(4), .IDX_W(4), .TRANSP_IDX(0)) dut1 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .rom_address(addr1), .rom_q(q1), .pal_red(pr1), .pal_green(pg1), .pal_blue(pb1),
      .red(r1), .green(g1), .blue(b1), .sprite_hit(hit1));

   sprite_overlay #(.SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE(3), .ADDR_W(4), .IDX_W(4), .TRANSP_IDX(0)) dut3 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
      .rom_address(addr3), .rom_q(q3), .pal_red(pr3), .pal_green(pg3), .pal_blue(pb3),
      .red(r3), .green(g3), .blue(b3), .sprite_hit(hit3));

   task automatic check_val(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic px_t model(input int sc, input int x, input int y);
      px_t e;
      int dx, dy;
      dx       = x - mpx;
      dy       = y - mpy;
      e.v      = 1'b1;
      e.blank  = blank;
      e.bg     = {bg_red, bg_green, bg_blue};
      e.inwin  = men && dx >= 0 && dx < SPR_W * sc && dy >= 0 && dy < SPR_H * sc;
      e.addr   = e.inwin ? 4'((dy / sc) * SPR_W + dx / sc) : 4'd0;
      return e;
   endfunction

   task automatic check_out(input string pfx, input px_t e, input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b, input logic hit);
      logic [3:0]  idx;
      logic [11:0] exp_rgb;
      logic        exp_hit;
      bit          opq;
      idx = rom_mem[e.addr];
`ifdef SPRITE_TRANSPARENCY_EN
      opq = (idx != 4'd0);
`else
      opq = 1'b1;
`endif
      exp_hit = 1'b0;
      if (!e.blank) begin
         exp_rgb = 12'h000;
      end else if (e.inwin && opq) begin
         exp_rgb = {idx, idx ^ 4'hA, ~idx};
         exp_hit = 1'b1;
      end else begin
         exp_rgb = e.bg;
      end
      check_val({pfx, "_rgb"}, int'({r, g, b}), int'(exp_rgb));
      check_val({pfx, "_hit"}, int'(hit), int'(exp_hit));
   endtask

   task automatic step(input int x, input int y);
      px_t c1, c3;
      if (x == 0 && y == 0) begin
         mpx = int'(pos_x);
         mpy = int'(pos_y);
         men = enable;
      end
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = (x < VIS_W && y < VIS_H) && (bg_fixed_red || $urandom_range(0, 15) != 0);
      if (bg_fixed_red) begin
         {bg_red, bg_green, bg_blue} = 12'hF00;
      end else begin
         {bg_red, bg_green, bg_blue} = 12'($urandom);
      end
      c1 = model(1, x, y);
      c3 = model(3, x, y);
      @(posedge vga_clk);
      #1;
      if (c1.inwin) check_val("s1_addr", int'(addr1), int'(c1.addr));
      if (c3.inwin) check_val("s3_addr", int'(addr3), int'(c3.addr));
      if (prev1.v) check_out("s1", prev1, r1, g1, b1, hit1);
      if (prev3.v) check_out("s3", prev3, r3, g3, b3, hit3);
      prev1 = c1;
      prev3 = c3;
   endtask

   task automatic check_zero(input string pfx);
      check_val({pfx, "_s1_rgb"},  int'({r1, g1, b1}), 0);
      check_val({pfx, "_s1_hit"},  int'(hit1), 0);
      check_val({pfx, "_s1_addr"}, int'(addr1), 0);
      check_val({pfx, "_s3_rgb"},  int'({r3, g3, b3}), 0);
      check_val({pfx, "_s3_hit"},  int'(hit3), 0);
      check_val({pfx, "_s3_addr"}, int'(addr3), 0);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1 check_zero("rst_mid");
      mpx      = 0;
      mpy      = 0;
      men      = 1'b0;
      prev1.v  = 1'b0;
      prev3.v  = 1'b0;
      repeat (2) @(posedge vga_clk);
      #2 reset = 1'b0;
   endtask

   task automatic set_pos(input int x, input int y, input bit en);
      pos_x  = 10'(x);
      pos_y  = 10'(y);
      enable = en;
   endtask

   initial begin
      rom_mem[0] = 4'd0;
      for (int i = 1; i < 16; i++) rom_mem[i] = 4'($urandom_range(0, 15));
      reset        = 1'b1;
      DrawX        = '0;
      DrawY        = 10'd1;
      blank        = 1'b0;
      pos_x        = '0;
      pos_y        = '0;
      enable       = 1'b0;
      {bg_red, bg_green, bg_blue} = 12'h000;
      mpx          = 0;
      mpy          = 0;
      men          = 1'b0;
      prev1        = '0;
      prev3        = '0;
      bg_fixed_red = 1'b0;
      #12;
      check_zero("rst_init");
      @(posedge vga_clk);
      #2 reset = 1'b0;

      for (int f = 0; f < NF; f++) begin
         bg_fixed_red = (f == 0);
         case (f)
            0, 1, 5, 6: set_pos(10, 5, 1'b1);
            2:          ;
            3:          set_pos(44, 3, 1'b1);
            4:          set_pos(0, 0, 1'b1);
            7:          set_pos(20, 8, 1'b0);
            default:    set_pos($urandom_range(0, H_TOT - SPR_W * 3), $urandom_range(0, V_TOT - SPR_H * 3),
                                $urandom_range(0, 3) != 0);
         endcase
         for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
               if (f == 1 && y == 8 && x == 0)  set_pos(40, 14, 1'b1);
               if (f == 1 && y == 10 && x == 0) enable = 1'b0;
               if (f == 1 && y == 12 && x == 0) enable = 1'b1;
               if (f == 5 && y == 6 && x == 12) do_reset();
               step(x, y);
            end
         end
      end
      step(0, 1);
      step(1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
